unroller: RTL and testbench

//  Inverse of the roller stage: collects ROLL_NUM-element beats and reassembles them into one
//  NUM-element vector. Sits at the consumer end of a rolled convolution datapath.

---
 rtl/unroller_pkg.sv | 20 ++
 rtl/unroller.sv | 109 ++++++++++
 tb/tb_unroller.sv | 230 +++++++++++++++++++++++
 3 files changed

// File: rtl/unroller_pkg.sv
// Shared convolution-datapath package: default geometry of the rolled
// datapath and helpers used to derive beat counts and counter widths.
package unroller_pkg;

    localparam int unsigned DEF_DATA_WIDTH = 16;
    localparam int unsigned DEF_NUM        = 8;
    localparam int unsigned DEF_ROLL_NUM   = 2;

    // Number of beats needed to carry one full vector.
    function automatic int unsigned beats_per_vector(input int unsigned num,
                                                     input int unsigned roll_num);
        return num / roll_num;
    endfunction

    // Counter width able to hold 0..cycles inclusive.
    function automatic int unsigned cnt_width(input int unsigned cycles);
        return (cycles < 1) ? 1 : $clog2(cycles + 1);
    endfunction

endpackage

// File: rtl/unroller.sv
// unroller: gathers ROLL_NUM-element beats into one NUM-element vector.
// The first beat of a vector ends up in the top elements, the last beat in
// the bottom ones, so it exactly undoes the roller. A fill shift register
// collects beats while a separate output register presents the previous
// vector, letting input keep streaming while the consumer stalls.
module unroller
    import unroller_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int unsigned NUM        = DEF_NUM,
    parameter int unsigned ROLL_NUM   = DEF_ROLL_NUM
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic [DATA_WIDTH*ROLL_NUM-1:0] data_in,
    input  logic                           data_in_valid,
    output logic                           data_in_ready,
    output logic [DATA_WIDTH*NUM-1:0]      data_out,
    output logic                           data_out_valid,
    input  logic                           data_out_ready
);

    localparam int unsigned CYCLES = beats_per_vector(NUM, ROLL_NUM);
    localparam int unsigned CNT_W  = cnt_width(CYCLES);
    localparam int unsigned VEC_W  = DATA_WIDTH * NUM;
    localparam int unsigned BEAT_W = DATA_WIDTH * ROLL_NUM;

    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(CYCLES);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CYCLES - 1);

    // A vector must split into a whole number of beats.
    if ((ROLL_NUM == 0) || (NUM % ROLL_NUM != 0)) begin : g_bad_ratio
        $error("unroller: NUM must be a non-zero multiple of ROLL_NUM");
    end

    logic [CNT_W-1:0] cnt_q,  cnt_d;
    logic [VEC_W-1:0] fill_q, fill_d;
    logic [VEC_W-1:0] out_q,  out_d;
    logic             out_vld_q, out_vld_d;

    logic             in_fire;
    logic             out_fire;
    logic [VEC_W-1:0] shifted;
    logic [VEC_W-1:0] assembled;
    logic             complete;
    logic             transfer;

    // With a single beat per vector the incoming beat is the whole vector;
    // otherwise older beats move up by one beat and the new one goes low.
    if (CYCLES == 1) begin : g_single_beat
        assign shifted = data_in;
    end else begin : g_multi_beat
        assign shifted = {fill_q[VEC_W-BEAT_W-1:0], data_in};
    end

    // Input is blocked during reset and while a finished vector is parked
    // in the fill register behind a stalled output.
    assign data_in_ready  = !rst && (cnt_q != CNT_FULL);
    assign data_out       = out_q;
    assign data_out_valid = out_vld_q;

    // Handshakes, completion detection and the vector to hand over.
    always_comb begin
        in_fire   = data_in_valid && data_in_ready;
        out_fire  = out_vld_q && data_out_ready;
        complete  = (cnt_q == CNT_FULL) || ((cnt_q == CNT_LAST) && in_fire);
        assembled = in_fire ? shifted : fill_q;
        transfer  = complete && (!out_vld_q || out_fire);
    end

    // Next-state: fill shifting, beat counting and output hand-over.
    always_comb begin
        cnt_d     = cnt_q;
        fill_d    = fill_q;
        out_d     = out_q;
        out_vld_d = out_vld_q;

        if (in_fire) begin
            fill_d = shifted;
            cnt_d  = cnt_q + CNT_W'(1);
        end

        if (transfer) begin
            // A finished vector moves to the output; the fill register
            // starts the next vector on the same cycle, so no bubble.
            out_d     = assembled;
            out_vld_d = 1'b1;
            cnt_d     = '0;
        end else if (out_fire) begin
            out_vld_d = 1'b0;
        end
    end

    // State registers; reset discards any partial vector and the output.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q     <= '0;
            fill_q    <= '0;
            out_q     <= '0;
            out_vld_q <= 1'b0;
        end else begin
            cnt_q     <= cnt_d;
            fill_q    <= fill_d;
            out_q     <= out_d;
            out_vld_q <= out_vld_d;
        end
    end

endmodule

// File: tb/tb_unroller.sv
// Directed bench for unroller: default geometry instance plus a
// single-beat (ROLL_NUM == NUM) instance driven with random handshakes.
module tb_unroller;

    logic         clk = 1'b0;
    logic         rst;

    logic [31:0]  din;
    logic         din_v;
    logic         din_r;
    logic [127:0] dout;
    logic         dout_v;
    logic         dout_r;

    logic [127:0] din2;
    logic         din_v2;
    logic         din_r2;
    logic [127:0] dout2;
    logic         dout_v2;
    logic         dout_r2;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    unroller #(.DATA_WIDTH(16), .NUM(8), .ROLL_NUM(2)) u_dut (
        .clk            (clk),
        .rst            (rst),
        .data_in        (din),
        .data_in_valid  (din_v),
        .data_in_ready  (din_r),
        .data_out       (dout),
        .data_out_valid (dout_v),
        .data_out_ready (dout_r)
    );

    unroller #(.DATA_WIDTH(16), .NUM(8), .ROLL_NUM(8)) u_one (
        .clk            (clk),
        .rst            (rst),
        .data_in        (din2),
        .data_in_valid  (din_v2),
        .data_in_ready  (din_r2),
        .data_out       (dout2),
        .data_out_valid (dout_v2),
        .data_out_ready (dout_r2)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Vector whose elements 7..0 are base+1 .. base+8.
    function automatic logic [127:0] vec(input int base);
        logic [127:0] v;
        for (int j = 0; j < 8; j++) v[j*16 +: 16] = 16'(base + 8 - j);
        return v;
    endfunction

    // Beat k of the vector above: {base+2k+1, base+2k+2}.
    function automatic logic [31:0] beat(input int base, input int k);
        return {16'(base + 2*k + 1), 16'(base + 2*k + 2)};
    endfunction

    function automatic logic [127:0] vec2(input int i);
        logic [127:0] v;
        for (int j = 0; j < 8; j++) v[j*16 +: 16] = 16'(16'h100 + i*16 + j);
        return v;
    endfunction

    task automatic send(input int base, input int k);
        din   = beat(base, k);
        din_v = 1'b1;
        tick();
    endtask

    initial begin
        int sent;
        int got;
        logic inf;
        logic outf;
        logic [127:0] cap;

        rst     = 1'b1;
        din     = '0;
        din_v   = 1'b0;
        dout_r  = 1'b1;
        din2    = '0;
        din_v2  = 1'b0;
        dout_r2 = 1'b0;
        tick();
        tick();

        // Reset state
        chk("rst_ready", 128'(din_r), 128'(0));
        chk("rst_valid", 128'(dout_v), 128'(0));
        chk("rst_data", dout, 128'(0));
        chk("rst_ready_one", 128'(din_r2), 128'(0));
        rst = 1'b0;
        #1;
        chk("post_rst_ready", 128'(din_r), 128'(1));

        // Test 1: single vector {1..8}, one-cycle valid pulse
        for (int k = 0; k < 4; k++) begin
            chk("t1_valid_low", 128'(dout_v), 128'(0));
            send(0, k);
        end
        din_v = 1'b0;
        chk("t1_valid", 128'(dout_v), 128'(1));
        chk("t1_data", dout, vec(0));
        tick();
        chk("t1_valid_drop", 128'(dout_v), 128'(0));

        // Test 2: three vectors back to back
        for (int v = 0; v < 3; v++) begin
            for (int k = 0; k < 4; k++) begin
                din   = beat(16 + v*8, k);
                din_v = 1'b1;
                #1;
                chk("t2_ready", 128'(din_r), 128'(1));
                tick();
                chk("t2_valid", 128'(dout_v), 128'(k == 3));
                if (k == 3) chk("t2_data", dout, vec(16 + v*8));
            end
        end
        din_v = 1'b0;
        tick();
        chk("t2_idle", 128'(dout_v), 128'(0));

        // Test 3: stalled output, 12 beats
        dout_r = 1'b0;
        for (int k = 0; k < 4; k++) send(32'h10, k);
        for (int k = 0; k < 4; k++) send(32'h20, k);
        chk("t3_ready_low", 128'(din_r), 128'(0));
        chk("t3_hold_a", dout, vec(32'h10));
        din = beat(32'h30, 0);
        tick();
        tick();
        chk("t3_still_a", dout, vec(32'h10));
        chk("t3_still_valid", 128'(dout_v), 128'(1));
        chk("t3_still_blocked", 128'(din_r), 128'(0));
        dout_r = 1'b1;
        tick();
        chk("t3_b", dout, vec(32'h20));
        chk("t3_b_valid", 128'(dout_v), 128'(1));
        chk("t3_ready_back", 128'(din_r), 128'(1));
        tick();
        chk("t3_gap", 128'(dout_v), 128'(0));
        for (int k = 1; k < 4; k++) send(32'h30, k);
        din_v = 1'b0;
        chk("t3_c", dout, vec(32'h30));
        chk("t3_c_valid", 128'(dout_v), 128'(1));
        tick();
        chk("t3_c_drop", 128'(dout_v), 128'(0));

        // Test 4: out_fire coincides with completion of the next vector
        dout_r = 1'b0;
        for (int k = 0; k < 4; k++) send(32'h40, k);
        for (int k = 0; k < 3; k++) send(32'h50, k);
        chk("t4_a", dout, vec(32'h40));
        din    = beat(32'h50, 3);
        din_v  = 1'b1;
        dout_r = 1'b1;
        tick();
        din_v = 1'b0;
        chk("t4_no_gap", 128'(dout_v), 128'(1));
        chk("t4_b", dout, vec(32'h50));
        tick();
        chk("t4_b_drop", 128'(dout_v), 128'(0));

        // Test 5: reset with a held vector and a partial vector
        dout_r = 1'b0;
        for (int k = 0; k < 4; k++) send(32'h60, k);
        for (int k = 0; k < 2; k++) send(32'h70, k);
        din_v = 1'b0;
        rst   = 1'b1;
        #1;
        chk("t5_ready_in_rst", 128'(din_r), 128'(0));
        tick();
        chk("t5_valid_cleared", 128'(dout_v), 128'(0));
        chk("t5_data_cleared", dout, 128'(0));
        rst    = 1'b0;
        dout_r = 1'b1;
        #1;
        chk("t5_ready", 128'(din_r), 128'(1));
        for (int k = 0; k < 3; k++) begin
            send(32'h80, k);
            chk("t5_no_partial", 128'(dout_v), 128'(0));
        end
        send(32'h80, 3);
        din_v = 1'b0;
        chk("t5_clean_valid", 128'(dout_v), 128'(1));
        chk("t5_clean_data", dout, vec(32'h80));
        tick();

        // Test 6: single-beat vectors with random valid/ready
        sent = 0;
        got  = 0;
        for (int cyc = 0; cyc < 400 && got < 20; cyc++) begin
            din_v2  = (sent < 20) && ($urandom_range(0, 3) != 0);
            din2    = vec2(sent);
            dout_r2 = ($urandom_range(0, 2) != 0);
            #1;
            inf  = din_v2 && din_r2;
            outf = dout_v2 && dout_r2;
            cap  = dout2;
            tick();
            if (inf) sent++;
            if (outf) begin
                chk("t6_vec", cap, vec2(got));
                got++;
            end
        end
        din_v2 = 1'b0;
        chk("t6_count", 128'(got), 128'(20));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
